// File: rtl/frame_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_seq_pkg : shared state encoding and sizing helper for frame_sequencer |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } frame_state_e;

  // Counters must hold every pixel of a frame plus the flush beats.
  function automatic int cnt_width(input int total, input int flush);
    return $clog2(total + flush + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/beat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_counter : clearable up-counter with terminal flag vs a runtime limit  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             term_o
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment so a frame boundary never leaks a beat.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || clr_i) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign term_o = (r_count == limit_i);

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_sequencer : forwards pixels, injects flush zeros, trims warm-up     |
// | results and reports frame completion for the Sobel pipeline.              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int width_p      = 641,
  parameter int height_p     = 480,
  parameter int data_width_p = 1,
  parameter int res_width_p  = 1,
  parameter int flush_p      = 2*width_p+2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    up_valid_i,
  output logic                    up_ready_o,
  input  logic [data_width_p-1:0] up_data_i,
  output logic                    dn_valid_o,
  input  logic                    dn_ready_i,
  output logic [data_width_p-1:0] dn_data_o,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [res_width_p-1:0]  res_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [res_width_p-1:0]  out_data_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic [7:0]              frame_cnt_o
);

  localparam int c_total = width_p * height_p;
  localparam int c_cnt_w = cnt_width(c_total, flush_p);

  localparam logic [c_cnt_w-1:0] c_total_m1 = c_cnt_w'(c_total - 1);
  localparam logic [c_cnt_w-1:0] c_flush_m1 = c_cnt_w'(flush_p - 1);
  localparam logic [c_cnt_w-1:0] c_flush    = c_cnt_w'(flush_p);

  frame_state_e       r_state;
  frame_state_e       w_state_nxt;
  logic               r_fwd_full;
  logic               r_frame_done;
  logic [7:0]         r_frame_cnt;

  logic               w_in_inc;
  logic               w_in_clr;
  logic               w_in_term;
  logic [c_cnt_w-1:0] w_in_limit;
  logic               w_drop_term;
  logic               w_fwd_term;
  logic               w_drop_phase;
  logic               w_fwd_phase;
  logic               w_drop_inc;
  logic               w_fwd_inc;
  logic               w_fwd_last;
  logic               w_fwd_reached;
  logic               w_complete;

  // Return path: drop warm-up results, forward one frame, then swallow extras.
  assign w_drop_phase  = !w_drop_term;
  assign w_fwd_phase   = w_drop_term && !r_fwd_full;
  assign res_ready_o   = reset_ni && (w_fwd_phase ? out_ready_i : 1'b1);
  assign out_valid_o   = w_fwd_phase && res_valid_i;
  assign out_data_o    = res_data_i;
  assign w_drop_inc    = w_drop_phase && res_valid_i && res_ready_o;
  assign w_fwd_inc     = out_valid_o && out_ready_i;
  // fwd_cnt terminates one short of the frame so the final beat is visible
  // combinationally; r_fwd_full remembers that it has been delivered.
  assign w_fwd_last    = w_fwd_inc && w_fwd_term;
  assign w_fwd_reached = r_fwd_full || w_fwd_last;

  assign w_in_limit = (r_state == FLUSH) ? c_flush_m1 : c_total_m1;
  assign w_in_clr   = w_complete || ((r_state == STREAM) && w_in_inc && w_in_term);

  always_comb begin
    w_state_nxt = r_state;
    up_ready_o  = 1'b0;
    dn_valid_o  = 1'b0;
    dn_data_o   = '0;
    w_in_inc    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (up_valid_i) w_state_nxt = STREAM;
      end
      STREAM: begin
        dn_valid_o = up_valid_i;
        up_ready_o = dn_ready_i;
        dn_data_o  = up_data_i;
        w_in_inc   = up_valid_i && dn_ready_i;
        if (w_in_inc && w_in_term) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        dn_valid_o = 1'b1;
        w_in_inc   = dn_ready_i;
        if (w_in_inc && w_in_term) begin
          w_state_nxt = DRAIN;
          w_complete  = w_fwd_reached;
        end
      end
      DRAIN: begin
        w_complete = w_fwd_reached;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_complete) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state      <= IDLE;
      r_fwd_full   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_complete;
      if (w_complete) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_fwd_full  <= 1'b0;
      end else if (w_fwd_last) begin
        r_fwd_full  <= 1'b1;
      end
    end
  end

  beat_counter #(.WIDTH(c_cnt_w)) u_in_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (w_in_inc),
    .clr_i    (w_in_clr),
    .limit_i  (w_in_limit),
    .term_o   (w_in_term)
  );

  beat_counter #(.WIDTH(c_cnt_w)) u_drop_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (w_drop_inc),
    .clr_i    (w_complete),
    .limit_i  (c_flush),
    .term_o   (w_drop_term)
  );

  beat_counter #(.WIDTH(c_cnt_w)) u_fwd_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (w_fwd_inc),
    .clr_i    (w_complete),
    .limit_i  (c_total_m1),
    .term_o   (w_fwd_term)
  );

  assign busy_o       = (r_state != IDLE);
  assign frame_done_o = r_frame_done;
  assign frame_cnt_o  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_sequencer : vector table, directed corners and random frames     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int TOT = 12;
  localparam int FL  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       up_valid = 1'b0;
  logic [7:0] up_data = 8'h00;
  logic       dn_ready = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       up_ready_o, dn_valid_o, res_ready_o, out_valid_o;
  logic       busy_o, frame_done_o;
  logic [7:0] dn_data_o, out_data_o, frame_cnt_o;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] fc_model = 8'd0;
  logic [7:0] src[$];

  always #5 clk = ~clk;

  frame_sequencer #(
    .width_p(4), .height_p(3), .data_width_p(8), .res_width_p(8)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .up_valid_i(up_valid), .up_ready_o(up_ready_o), .up_data_i(up_data),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready), .dn_data_o(dn_data_o),
    .res_valid_i(res_valid), .res_ready_o(res_ready_o), .res_data_i(res_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel i of frame f on the filter side: source pixels, then flush zeros.
  function automatic logic [7:0] exp_dn(input int f, input int i);
    if (i >= TOT) return 8'h00;
    if (f*TOT + i >= src.size()) return 8'h00;
    return src[f*TOT + i];
  endfunction

  task automatic idle_inputs();
    up_valid = 1'b0; up_data = 8'h00; dn_ready = 1'b0;
    res_valid = 1'b0; res_data = 8'h00; out_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle_inputs();
    repeat (n) @(posedge clk);
    #1 reset_n = 1'b1;
    fc_model = 8'd0;
  endtask

  // Runs nfr frames against a filter that echoes each pixel one cycle later.
  task automatic run_frames(input int nfr, input int dn_pct, input int out_pct, input int budget);
    logic [7:0] fq[$];
    int         src_idx, m_frame, dn_got, res_got, out_got, cyc;
    bit         m_active, done_exp, pdn_stall, pout_stall;
    bit         up_fire, dn_fire, res_fire, out_fire;
    logic [7:0] pdn_data, pout_data;
    src.delete();
    for (int i = 0; i < nfr*TOT; i++) src.push_back(8'($urandom_range(1, 255)));
    src_idx = 0; m_frame = 0; dn_got = 0; res_got = 0; out_got = 0; cyc = 0;
    m_active = 0; done_exp = 0; pdn_stall = 0; pout_stall = 0;
    pdn_data = 8'h00; pout_data = 8'h00;
    while ((m_frame < nfr || done_exp) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      up_valid  = (src_idx < src.size());
      up_data   = up_valid ? src[src_idx] : 8'h00;
      dn_ready  = ($urandom_range(0, 99) < dn_pct);
      res_valid = (fq.size() > 0);
      res_data  = res_valid ? fq[0] : 8'h00;
      out_ready = ($urandom_range(0, 99) < out_pct);
      #4;
      check("busy", busy_o, m_active);
      check("frame_done", frame_done_o, done_exp);
      check("frame_cnt", frame_cnt_o, fc_model);
      if (!m_active) begin
        check("idle_up_ready", up_ready_o, 1'b0);
        check("idle_dn_valid", dn_valid_o, 1'b0);
      end else if (dn_got < TOT) begin
        check("pass_dn_valid", dn_valid_o, up_valid);
        check("pass_up_ready", up_ready_o, dn_ready);
        if (up_valid) check("pass_dn_data", dn_data_o, up_data);
      end else if (dn_got < TOT + FL) begin
        check("flush_up_ready", up_ready_o, 1'b0);
        check("flush_dn_valid", dn_valid_o, 1'b1);
        check("flush_dn_data", dn_data_o, 8'h00);
      end else begin
        check("drain_up_ready", up_ready_o, 1'b0);
        check("drain_dn_valid", dn_valid_o, 1'b0);
      end
      if (pdn_stall) begin
        check("dn_hold_valid", dn_valid_o, 1'b1);
        check("dn_hold_data", dn_data_o, pdn_data);
      end
      if (res_got < FL) begin
        check("drop_res_ready", res_ready_o, 1'b1);
        check("drop_out_valid", out_valid_o, 1'b0);
      end else if (out_got < TOT) begin
        check("fwd_out_valid", out_valid_o, res_valid);
        check("fwd_res_ready", res_ready_o, out_ready);
        if (res_valid) check("fwd_out_data", out_data_o, res_data);
      end else begin
        check("excess_res_ready", res_ready_o, 1'b1);
        check("excess_out_valid", out_valid_o, 1'b0);
      end
      if (pout_stall) begin
        check("out_hold_valid", out_valid_o, 1'b1);
        check("out_hold_data", out_data_o, pout_data);
      end
      up_fire  = up_valid && up_ready_o;
      dn_fire  = dn_valid_o && dn_ready;
      res_fire = res_valid && res_ready_o;
      out_fire = out_valid_o && out_ready;
      pdn_stall = dn_valid_o && !dn_ready;   pdn_data  = dn_data_o;
      pout_stall = out_valid_o && !out_ready; pout_data = out_data_o;
      if (up_fire) src_idx++;
      if (res_fire && fq.size() > 0) void'(fq.pop_front());
      if (dn_fire) begin
        check("dn_sequence", dn_data_o, exp_dn(m_frame, dn_got));
        fq.push_back(dn_data_o);
        dn_got++;
      end
      if (res_fire && res_got < FL) begin
        res_got++;
      end else if (out_fire) begin
        check("out_sequence", out_data_o, exp_dn(m_frame, FL + out_got));
        out_got++;
      end
      done_exp = 0;
      if (m_active && dn_got == TOT + FL && out_got == TOT) begin
        done_exp = 1; m_active = 0;
        dn_got = 0; res_got = 0; out_got = 0;
        fc_model = fc_model + 8'd1;
        m_frame++;
      end else if (!m_active && up_valid) begin
        m_active = 1;
      end
    end
    if (m_frame < nfr) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d of %0d frames done after %0d cycles", m_frame, nfr, cyc);
    end
    idle_inputs();
  endtask

  typedef struct {
    logic       uv; logic [7:0] ud; logic dr;
    logic       rv; logic [7:0] rd; logic orr;
    logic       e_ur; logic e_dv; logic [7:0] e_dd;
    logic       e_rr; logic e_ov; logic e_busy;
  } vec_t;

  vec_t vt[8];
  int   ups;

  initial begin
    // Columns: uv ud dr rv rd or | up_ready dn_valid dn_data res_ready out_valid busy
    vt[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1};

    // Reset held for three cycles, then released with no input.
    idle_inputs();
    repeat (3) @(posedge clk);
    #4;
    check("rst_up_ready", up_ready_o, 1'b0);
    check("rst_dn_valid", dn_valid_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_res_ready", res_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_frame_done", frame_done_o, 1'b0);
    check("rst_frame_cnt", frame_cnt_o, 8'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #4;
      check("idle_busy", busy_o, 1'b0);
      check("idle_res_ready", res_ready_o, 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      up_valid = vt[i].uv; up_data = vt[i].ud; dn_ready = vt[i].dr;
      res_valid = vt[i].rv; res_data = vt[i].rd; out_ready = vt[i].orr;
      #4;
      check($sformatf("vec%0d_up_ready", i), up_ready_o, vt[i].e_ur);
      check($sformatf("vec%0d_dn_valid", i), dn_valid_o, vt[i].e_dv);
      if (vt[i].e_dv) check($sformatf("vec%0d_dn_data", i), dn_data_o, vt[i].e_dd);
      check($sformatf("vec%0d_res_ready", i), res_ready_o, vt[i].e_rr);
      check($sformatf("vec%0d_out_valid", i), out_valid_o, vt[i].e_ov);
      check($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
    end

    // Streaming and return path with no backpressure, then random stalls.
    do_reset(2);
    run_frames(1, 100, 100, 500);
    run_frames(1, 50, 50, 2000);

    // Back-to-back frames: next frame's pixels wait during DRAIN.
    do_reset(2);
    run_frames(3, 70, 60, 4000);

    // Mid-frame reset after seven accepted pixels.
    ups = 0;
    for (int c = 0; c < 30 && ups < 7; c++) begin
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = 8'($urandom_range(1, 255)); dn_ready = 1'b1;
      #4;
      if (up_valid && up_ready_o) ups++;
    end
    check("midreset_pixels", ups, 7);
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk); #4;
    check("midreset_busy", busy_o, 1'b0);
    check("midreset_up_ready", up_ready_o, 1'b0);
    check("midreset_dn_valid", dn_valid_o, 1'b0);
    check("midreset_out_valid", out_valid_o, 1'b0);
    check("midreset_res_ready", res_ready_o, 1'b0);
    check("midreset_frame_cnt", frame_cnt_o, 8'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    fc_model = 8'd0;
    run_frames(1, 80, 80, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
